bist_controller: RTL and testbench

- Sequencer for the scan-based BIST loop around the TRCUT-with-MISR datapath.
- On START it:
  - resets the pattern generator, CUT and MISR;
  - runs NUM_VECTORS shift/capture pairs by driving SE;
  - flushes the last capture;
  - unloads the serial MISR signature and compares it against a golden value.
- Replaces the hand-timed SE/sampling sequence in the bench, so BIST can run in-system and report PASS/DONE.

---
 rtl/bist_controller.sv | 99 +++++++++
 tb/tb_bist_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// Sequencer for the scan-based BIST loop: reset, NUM_VECTORS shift/capture pairs,
// a flush shift, serial signature unload and golden compare.
module bist_controller #(
    parameter int                    CHAIN_LEN   = 4,
    parameter int                    NUM_VECTORS = 32,
    parameter int                    SIGN_WIDTH  = 16,
    parameter logic [SIGN_WIDTH-1:0] GOLDEN      = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               START,
    input  logic                               ABORT,
    input  logic                               SIGN,
    output logic                               SE,
    output logic                               BIST_RST,
    output logic                               UNLOAD,
    output logic                               BUSY,
    output logic                               DONE,
    output logic                               PASS,
    output logic [SIGN_WIDTH-1:0]              SIGN_OUT,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   VEC_CNT
);
    localparam int VW   = $clog2(NUM_VECTORS + 1);
    localparam int CMAX = (CHAIN_LEN > SIGN_WIDTH) ? CHAIN_LEN : SIGN_WIDTH;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_UNLOAD  = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;

    logic [2:0]    state, nxt;
    logic [CW-1:0] cnt;
    logic          abort_run;

    assign abort_run = ABORT && (state != S_IDLE);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (START && !ABORT) nxt = S_INIT;
            S_INIT:    nxt = S_SHIFT;
            // the pass that sees VEC_CNT==NUM_VECTORS is the flush shift
            S_SHIFT:   if (cnt == CW'(CHAIN_LEN - 1))
                           nxt = (VEC_CNT < VW'(NUM_VECTORS)) ? S_CAPTURE : S_UNLOAD;
            S_CAPTURE: nxt = S_SHIFT;
            S_UNLOAD:  if (cnt == CW'(SIGN_WIDTH - 1)) nxt = S_COMPARE;
            S_COMPARE: nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (abort_run) nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            SE       <= 1'b0;
            BIST_RST <= 1'b0;
            UNLOAD   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            SIGN_OUT <= '0;
            VEC_CNT  <= '0;
        end else begin
            state    <= nxt;
            cnt      <= (nxt != state || state == S_IDLE) ? '0 : cnt + CW'(1);
            // strobes are registered from the next state so they line up with it
            SE       <= (nxt == S_SHIFT);
            BIST_RST <= (nxt == S_INIT);
            UNLOAD   <= (nxt == S_UNLOAD);
            BUSY     <= (nxt != S_IDLE);

            if (state == S_IDLE && nxt == S_INIT) begin
                DONE     <= 1'b0;
                PASS     <= 1'b0;
                SIGN_OUT <= '0;
                VEC_CNT  <= '0;
            end
            if (state == S_CAPTURE && !abort_run)
                VEC_CNT <= VEC_CNT + VW'(1);
            if (state == S_UNLOAD && !abort_run) begin
                for (int i = 0; i < SIGN_WIDTH; i++)
                    if (cnt == CW'(i)) SIGN_OUT[i] <= SIGN;
            end
            if (state == S_COMPARE && !abort_run) begin
                PASS <= (SIGN_OUT == GOLDEN);
                DONE <= 1'b1;
            end
            if (abort_run) begin
                DONE <= 1'b0;
                PASS <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: timing, waveform counts, restart/abort/reset cases.
module tb_bist_controller;
    logic        CLK = 1'b0;
    logic        RST, START, ABORT, SIGN;
    logic        SE, BIST_RST, UNLOAD, BUSY, DONE, PASS;
    logic [15:0] SIGN_OUT;
    logic [5:0]  VEC_CNT;

    int vectors = 0, miscompares = 0;
    int k, done_at, ubit;
    int se_cnt, bursts, gaps, low_run, bist_rst_cnt, unload_cnt, unload_run, unload_max, busy_cnt;
    logic prev_se;
    logic [15:0] sig_pat;

    bist_controller dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .SIGN(SIGN),
        .SE(SE), .BIST_RST(BIST_RST), .UNLOAD(UNLOAD), .BUSY(BUSY), .DONE(DONE),
        .PASS(PASS), .SIGN_OUT(SIGN_OUT), .VEC_CNT(VEC_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, record waveform stats, drive SIGN.
    task automatic tick();
        @(negedge CLK);
        k++;
        if (DONE && done_at < 0) done_at = k;
        if (SE) begin
            if (!prev_se) begin
                if (bursts > 0 && low_run == 1) gaps++;
                bursts++;
            end
            se_cnt++;
            low_run = 0;
        end else low_run++;
        prev_se = SE;
        if (BIST_RST) bist_rst_cnt++;
        if (BUSY) busy_cnt++;
        if (UNLOAD) begin
            unload_cnt++;
            unload_run++;
            if (unload_run > unload_max) unload_max = unload_run;
        end else unload_run = 0;
        if (UNLOAD && ubit < 16) begin
            SIGN = sig_pat[ubit[3:0]];
            ubit++;
        end else begin
            SIGN = 1'b0;
            ubit = 0;
        end
    endtask

    // Start a run at edge t, then apply ncyc more edges; START/ABORT pulses at edge t+N.
    task automatic run(input logic [15:0] pat, input int ncyc, input int pulse_at, input int abort_at);
        sig_pat = pat;
        k = -1; done_at = -1; ubit = 0;
        se_cnt = 0; bursts = 0; gaps = 0; low_run = 0; prev_se = 1'b0;
        bist_rst_cnt = 0; unload_cnt = 0; unload_run = 0; unload_max = 0; busy_cnt = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            START = (i == pulse_at);
            ABORT = (i == abort_at);
            tick();
        end
        START = 1'b0;
        ABORT = 1'b0;
    endtask

    initial begin
        RST = 1'b0; START = 1'b0; ABORT = 1'b0; SIGN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_outs", {26'd0, SE, BIST_RST, UNLOAD, BUSY, DONE, PASS}, 32'd0);
        chk("rst_sign_out", 32'(SIGN_OUT), 32'd0);
        chk("rst_vec_cnt", 32'(VEC_CNT), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Fault-free run, signature 0 == GOLDEN; full waveform accounting.
        run(16'h0000, 185, 0, 0);
        chk("a_done_at", 32'(done_at), 32'd182);
        chk("a_pass", 32'(PASS), 32'd1);
        chk("a_sign_out", 32'(SIGN_OUT), 32'h0000);
        chk("a_vec_cnt", 32'(VEC_CNT), 32'd32);
        chk("a_bist_rst_cycles", 32'(bist_rst_cnt), 32'd1);
        chk("a_se_cycles", 32'(se_cnt), 32'd132);
        chk("a_se_bursts", 32'(bursts), 32'd33);
        chk("a_se_gaps", 32'(gaps), 32'd32);
        chk("a_unload_cycles", 32'(unload_cnt), 32'd16);
        chk("a_unload_run", 32'(unload_max), 32'd16);
        chk("a_busy_cycles", 32'(busy_cnt), 32'd182);

        // SIGN stuck high during unload.
        run(16'hFFFF, 183, 0, 0);
        chk("b_done_at", 32'(done_at), 32'd182);
        chk("b_sign_out", 32'(SIGN_OUT), 32'hFFFF);
        chk("b_pass", 32'(PASS), 32'd0);
        chk("b_done", 32'(DONE), 32'd1);

        // Bit ordering (LSB first) plus a START pulse at vector 10 while busy.
        run(16'hA5C3, 183, 52, 0);
        chk("c_done_at", 32'(done_at), 32'd182);
        chk("c_sign_out", 32'(SIGN_OUT), 32'hA5C3);
        chk("c_vec_cnt", 32'(VEC_CNT), 32'd32);
        chk("c_busy_cycles", 32'(busy_cnt), 32'd182);
        chk("c_pass", 32'(PASS), 32'd0);

        // START held across DONE restarts on the first idle cycle.
        run(16'h0000, 182, 0, 0);
        chk("d_done", 32'(DONE), 32'd1);
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("d_restart", {29'd0, DONE, BUSY, BIST_RST}, 32'b011);
        chk("d_restart_vec", 32'(VEC_CNT), 32'd0);
        tick(); tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("d_abort_shift", {29'd0, SE, BUSY, DONE}, 32'd0);
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("d_abort_prio", {30'd0, BUSY, BIST_RST}, 32'd0);

        // Asynchronous reset mid-shift of vector 21.
        run(16'h0000, 107, 0, 0);
        chk("e_pre_vec", 32'(VEC_CNT), 32'd21);
        chk("e_pre_se", 32'(SE), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("e_rst_outs", {29'd0, SE, BUSY, DONE}, 32'd0);
        chk("e_rst_vec", 32'(VEC_CNT), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        run(16'h0000, 184, 0, 0);
        chk("e_rerun_done_at", 32'(done_at), 32'd182);
        chk("e_rerun_vec", 32'(VEC_CNT), 32'd32);
        chk("e_rerun_pass", 32'(PASS), 32'd1);

        // ABORT while unloading bit 5: bits 4:0 kept, bit 5 not captured.
        run(16'hFFFF, 171, 0, 171);
        chk("f_abort_state", {27'd0, SE, UNLOAD, BUSY, DONE, PASS}, 32'd0);
        chk("f_sign_out", 32'(SIGN_OUT), 32'h001F);
        chk("f_vec_cnt", 32'(VEC_CNT), 32'd32);
        chk("f_done_at", 32'(done_at), 32'hFFFFFFFF);
        run(16'h0000, 2, 0, 0);
        chk("f_fresh_sign_out", 32'(SIGN_OUT), 32'h0000);
        chk("f_fresh_busy", 32'(BUSY), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
